viterbi_frame_decoder: RTL and testbench
========================================

Name: viterbi_frame_decoder

Overview:
- Sequential hard-decision Viterbi decoder: parametrised, clocked successor to our combinational per-symbol decoder.
- Decodes one frame of N_SYM rate-1/2, K=3 symbols (generators g1=111, g2=101) from our convolutional encoder.
- Accepts one 2-bit symbol per cycle over a valid/ready handshake and keeps its own path metrics and survivor memory.
- Performs traceback, then presents the decoded frame in parallel with its final path metric.

Parameters:
- N_SYM, 11, symbols per frame = decoded bits per frame (>=3).
- METRIC_W, 5, path-metric width. Must satisfy 2^METRIC_W-1 >= 2*N_SYM. Metrics saturate at 2^METRIC_W-1.
- TERMINATED, 1, 1: traceback starts from state 0 (encoder flushed with two zero tail bits). 0: traceback starts from the minimum-metric state.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous frame abort, returns to ACCEPT with metrics re-initialised
- in_valid  in  1  symbol valid
- in_ready  out  1  decoder can accept a symbol
- in_sym  in  2  [1]=g1 output, [0]=g2 output
- out_valid  out  1  decoded frame available
- out_ready  in  1  consumer takes the frame
- out_data  out  N_SYM  decoded bits; first symbol's bit at [N_SYM-1]
- out_metric  out  METRIC_W  final path metric of traced state (Hamming errors corrected)
- busy  out  1  high in TRACE or DONE

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_metric=0, busy=0, FSM=ACCEPT, sym_cnt=0.
- Reset path metrics: PM[0]=0, PM[1..3]=2^METRIC_W-1.
- State encoding: s={s1,s0}, where s1 is the most recent input bit.
  - Input u gives next state {u,s1}.
  - Expected symbol: g1=u^s1^s0, g2=u^s0.
- ACS (ACCEPT state, on in_valid&&in_ready):
  - Predecessors of ns are {ns[0],0} and {ns[0],1}.
  - Candidate = PM[pred] + Hamming(in_sym, expected), saturating.
  - Pick the smaller candidate; on a tie, pick pred with s0=0.
  - Store decision bit (chosen pred's s0) at survivor[sym_cnt][ns].
  - All 4 states update in the same cycle. Increment sym_cnt.
- FSM:
  - ACCEPT: in_ready=1. On the handshake for the N_SYM-th symbol, go to TRACE with sym_cnt=N_SYM-1. Start state: 0 if TERMINATED, else the lowest-index minimum of the just-updated metrics. Latch out_metric from that state's metric.
  - TRACE: in_ready=0. One step per cycle:
    - out_data[N_SYM-1-sym_cnt] = cur[1].
    - cur <= {cur[0], survivor[sym_cnt][cur]}.
    - Decrement sym_cnt.
    - After the step at sym_cnt=0, go to DONE.
    - Exactly N_SYM cycles.
  - DONE: out_valid=1; out_data and out_metric held stable. On out_ready, go to ACCEPT: out_valid=0, metrics re-initialised, sym_cnt=0.
- Latency: last symbol accepted in cycle c; out_valid first high in cycle c+N_SYM+1.
- Back-pressure: out_valid stays high indefinitely while out_ready=0. in_ready is 0 throughout TRACE and DONE.
- in_valid outside ACCEPT is ignored. No symbol is lost because in_ready=0.
- clr in any state: next cycle is ACCEPT with reset metrics, sym_cnt=0, out_valid=0. out_data is retained.
  - clr has priority over a simultaneous symbol handshake (symbol dropped) and over out_ready.
- rst_n asserted mid-frame or mid-trace: immediate return to reset values. The partial frame is discarded.
- Saturation: an adder result above 2^METRIC_W-1 clamps to 2^METRIC_W-1. No wrap-around.
- Survivor memory: N_SYM x 4 flops. It is not cleared; every entry is written before it is read.

Decomposition:
- Package viterbi_pkg holds:
  - NUM_STATES=4 and the G1/G2 generator constants.
  - FSM state enum {ACCEPT, TRACE, DONE}.
  - Function exp_sym(state, u) returning the 2-bit expected symbol.
  - Function hamming2(a, b).
- One sub-module, viterbi_acs: a single add-compare-select unit (two metrics and two branch costs in, saturating winning metric and decision bit out).
  - Instantiate it 4 times in viterbi_frame_decoder.

Test Plan:
- Clean frame (N_SYM=11, TERMINATED=1): symbols 11,10,00,01,01,00,10,11,11,10,11 back-to-back -> out_data=11'b10110100100, out_metric=0, out_valid in cycle c+12 after last symbol.
- Single error: same frame with third symbol sent as 10 -> out_data=11'b10110100100, out_metric=1.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> out_valid, out_data and out_metric stable, in_ready=0. out_ready=1 -> in_ready=1 the next cycle; second frame decodes correctly.
- Gapped input: in_valid toggled 1,0,0,1,... -> same result as back-to-back; only handshaked symbols counted.
- clr after 5 symbols, same cycle as in_valid -> symbol dropped, sym_cnt=0; subsequent full clean frame decodes to 11'b10110100100.
- Async reset mid-TRACE -> all outputs at reset values immediately; next full frame decodes correctly. With TERMINATED=0, an all-00 frame gives out_data=0 and out_metric=0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants, FSM state type and branch-metric helpers for the K=3,
// rate-1/2 hard-decision Viterbi frame decoder.
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G2 = 3'b101;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    TRACE  = 2'd1,
    DONE   = 2'd2
  } fsm_t;

  // Encoder register is {u, s1, s0}; each generator taps it and XOR-reduces.
  function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic u);
    logic [2:0] taps;
    taps = {u, state};
    return {^(taps & G1), ^(taps & G2)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Single add-compare-select unit: saturating sums of two path metrics and
// branch costs, keeps the smaller one (ties go to predecessor a, s0=0).
module viterbi_acs #(
  parameter int METRIC_W = 5
) (
  input  logic [METRIC_W-1:0] pm_a,
  input  logic [METRIC_W-1:0] pm_b,
  input  logic [1:0]          bm_a,
  input  logic [1:0]          bm_b,
  output logic [METRIC_W-1:0] pm_out,
  output logic                dec
);

  localparam logic [METRIC_W-1:0] PM_MAX = '1;

  logic [METRIC_W:0]   sum_a;
  logic [METRIC_W:0]   sum_b;
  logic [METRIC_W-1:0] cand_a;
  logic [METRIC_W-1:0] cand_b;

  assign sum_a  = {1'b0, pm_a} + {{(METRIC_W-1){1'b0}}, bm_a};
  assign sum_b  = {1'b0, pm_b} + {{(METRIC_W-1){1'b0}}, bm_b};
  assign cand_a = sum_a[METRIC_W] ? PM_MAX : sum_a[METRIC_W-1:0];
  assign cand_b = sum_b[METRIC_W] ? PM_MAX : sum_b[METRIC_W-1:0];

  assign dec    = (cand_b < cand_a);
  assign pm_out = dec ? cand_b : cand_a;

endmodule

// File: rtl/viterbi_frame_decoder.sv
// Frame-based hard-decision Viterbi decoder (K=3, g1=111, g2=101): ACS per
// accepted symbol, N_SYM-cycle traceback, then parallel frame hand-off.
//
//   state  | meaning
//   ACCEPT | taking symbols, updating metrics and survivors
//   TRACE  | walking survivors back, one decoded bit per cycle
//   DONE   | frame presented, waiting for out_ready
module viterbi_frame_decoder
  import viterbi_pkg::*;
#(
  parameter int N_SYM      = 11,
  parameter int METRIC_W   = 5,
  parameter int TERMINATED = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sym,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_SYM-1:0]    out_data,
  output logic [METRIC_W-1:0] out_metric,
  output logic                busy
);

  localparam int CNT_W = $clog2(N_SYM);
  localparam logic [METRIC_W-1:0] PM_MAX  = '1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(N_SYM - 1);

  fsm_t                  state;
  logic [CNT_W-1:0]      sym_cnt;
  logic [1:0]            cur;
  logic [METRIC_W-1:0]   pm     [NUM_STATES];
  logic [METRIC_W-1:0]   pm_new [NUM_STATES];
  logic [NUM_STATES-1:0] dec_new;
  logic [NUM_STATES-1:0] surv   [N_SYM];
  logic [1:0]            start_state;
  logic [METRIC_W-1:0]   start_pm;
  logic                  accept;

  assign accept = in_valid && in_ready;

  // Next state ns = {u, s1}; its predecessors share s1 = ns[0] and differ in s0.
  for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
    localparam logic [1:0] NS     = 2'(ns);
    localparam logic [1:0] PRED_A = {NS[0], 1'b0};
    localparam logic [1:0] PRED_B = {NS[0], 1'b1};

    viterbi_acs #(.METRIC_W(METRIC_W)) u_acs (
      .pm_a   (pm[PRED_A]),
      .pm_b   (pm[PRED_B]),
      .bm_a   (hamming2(in_sym, exp_sym(PRED_A, NS[1]))),
      .bm_b   (hamming2(in_sym, exp_sym(PRED_B, NS[1]))),
      .pm_out (pm_new[ns]),
      .dec    (dec_new[ns])
    );
  end

  always_comb begin
    start_state = 2'd0;
    start_pm    = pm_new[0];
    if (TERMINATED == 0) begin
      for (int i = 1; i < NUM_STATES; i++) begin
        if (pm_new[i] < start_pm) begin
          start_pm    = pm_new[i];
          start_state = 2'(i);
        end
      end
    end
  end

  // Survivor memory is never cleared: every entry is written before traceback reads it.
  always_ff @(posedge clk) begin
    if (accept && !clr) begin
      surv[sym_cnt] <= dec_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCEPT;
      sym_cnt    <= '0;
      cur        <= 2'd0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_metric <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < NUM_STATES; i++) pm[i] <= (i == 0) ? '0 : PM_MAX;
    end else if (clr) begin
      state     <= ACCEPT;
      sym_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_STATES; i++) pm[i] <= (i == 0) ? '0 : PM_MAX;
    end else begin
      case (state)
        ACCEPT: begin
          if (accept) begin
            for (int i = 0; i < NUM_STATES; i++) pm[i] <= pm_new[i];
            if (sym_cnt == CNT_LAST) begin
              state      <= TRACE;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
              cur        <= start_state;
              out_metric <= start_pm;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
        end
        TRACE: begin
          for (int i = 0; i < N_SYM; i++) begin
            if (sym_cnt == CNT_W'(N_SYM - 1 - i)) out_data[i] <= cur[1];
          end
          cur <= {cur[0], surv[sym_cnt][cur]};
          if (sym_cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            sym_cnt <= sym_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCEPT;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            sym_cnt   <= '0;
            for (int i = 0; i < NUM_STATES; i++) pm[i] <= (i == 0) ? '0 : PM_MAX;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_frame_decoder.sv
// Scoreboard bench for viterbi_frame_decoder: an independent encoder model
// builds each frame, expected bits/metric are queued and checked on output.
module tb_viterbi_frame_decoder;

  localparam int N_SYM    = 11;
  localparam int METRIC_W = 5;
  localparam logic [N_SYM-1:0] CLEAN = 11'b10110100100;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clr = 1'b0;
  logic                in_valid = 1'b0;
  logic [1:0]          in_sym = 2'b00;
  logic                out_ready = 1'b0;
  logic                in_ready, out_valid, busy;
  logic [N_SYM-1:0]    out_data;
  logic [METRIC_W-1:0] out_metric;
  logic                nt_in_ready, nt_out_valid, nt_busy;
  logic [N_SYM-1:0]    nt_out_data;
  logic [METRIC_W-1:0] nt_out_metric;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [N_SYM-1:0]    data;
    logic [METRIC_W-1:0] metric;
    bit                  chk_nt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  viterbi_frame_decoder #(.N_SYM(N_SYM), .METRIC_W(METRIC_W), .TERMINATED(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_sym(in_sym), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_metric(out_metric), .busy(busy)
  );

  viterbi_frame_decoder #(.N_SYM(N_SYM), .METRIC_W(METRIC_W), .TERMINATED(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(nt_in_ready),
    .in_sym(in_sym), .out_valid(nt_out_valid), .out_ready(out_ready), .out_data(nt_out_data),
    .out_metric(nt_out_metric), .busy(nt_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; err_a flips g1 of that symbol, err_b flips g2.
  task automatic send_frame(input logic [N_SYM-1:0] bits, input int nsym, input int err_a,
                            input int err_b, input bit gapped, input bit push);
    logic s1, s0, u;
    logic [1:0] sym;
    int errs;
    s1 = 1'b0;
    s0 = 1'b0;
    errs = (err_a >= 0 ? 1 : 0) + (err_b >= 0 ? 1 : 0);
    for (int k = 0; k < nsym; k++) begin
      u   = bits[N_SYM-1-k];
      sym = {u ^ s1 ^ s0, u ^ s0};
      if (k == err_a) sym[1] = ~sym[1];
      if (k == err_b) sym[0] = ~sym[0];
      s0 = s1;
      s1 = u;
      if (gapped && k > 0) begin
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      in_valid = 1'b1;
      in_sym   = sym;
      if (push && k == nsym - 1)
        sb.push_back('{data: bits, metric: METRIC_W'(errs), chk_nt: (errs == 0)});
      chk("in_ready_accept", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Entered at the negedge right after the last handshake.
  task automatic collect(input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    chk("busy_trace", 32'(busy), 32'd1);
    chk("in_ready_trace", 32'(in_ready), 32'd0);
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(N_SYM));
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      chk("out_data", 32'(out_data), 32'(e.data));
      chk("out_metric", 32'(out_metric), 32'(e.metric));
      if (e.chk_nt) begin
        chk("nt_out_valid", 32'(nt_out_valid), 32'd1);
        chk("nt_out_data", 32'(nt_out_data), 32'(e.data));
        chk("nt_out_metric", 32'(nt_out_metric), 32'(e.metric));
      end
      for (int c = 0; c < hold; c++) begin
        in_valid = 1'b1;
        in_sym   = 2'b11;
        @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(e.data));
        chk("hold_metric", 32'(out_metric), 32'(e.metric));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [8:0] r;
    int ea, eb;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_metric", 32'(out_metric), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(CLEAN, N_SYM, -1, -1, 1'b0, 1'b1);
    collect(0);

    send_frame(CLEAN, N_SYM, 2, -1, 1'b0, 1'b1);
    collect(0);

    send_frame(CLEAN, N_SYM, -1, -1, 1'b0, 1'b1);
    collect(20);
    send_frame(11'b01101011000, N_SYM, 7, -1, 1'b0, 1'b1);
    collect(0);

    send_frame(CLEAN, N_SYM, -1, -1, 1'b1, 1'b1);
    collect(0);

    send_frame(CLEAN, 5, -1, -1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_sym   = 2'b01;
    clr      = 1'b1;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_out_data_kept", 32'(out_data), 32'(CLEAN));
    send_frame(CLEAN, N_SYM, -1, -1, 1'b0, 1'b1);
    collect(0);

    send_frame(CLEAN, N_SYM, -1, -1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_metric", 32'(out_metric), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame('0, N_SYM, -1, -1, 1'b0, 1'b1);
    collect(0);
    send_frame(CLEAN, N_SYM, -1, -1, 1'b0, 1'b1);
    collect(0);

    for (int i = 0; i < 9; i++) begin
      r  = 9'($urandom);
      ea = (i % 3 >= 1) ? int'($urandom_range(0, N_SYM - 1)) : -1;
      eb = (i % 3 == 2) ? int'($urandom_range(0, N_SYM - 1)) : -1;
      send_frame({r, 2'b00}, N_SYM, ea, eb, i[0], 1'b1);
      collect(i % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
